// File: rtl/delay_unit_pkg.sv
// Shared constants and stage record for the delay-unit hierarchy.
package delay_unit_pkg;

    localparam int DELAY_WIDTH = 5;
    localparam int DELAY_DEPTH = 3;

    typedef struct packed {
        logic                   valid;
        logic [DELAY_WIDTH-1:0] data;
    } delay_stage_t;

endpackage

// File: rtl/delay_lane.sv
// One elastic delay chain: DEPTH {valid, data} stages with valid/ready flow control.
module delay_lane #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t             stage_q [DEPTH];
    stage_t             stage_d [DEPTH];
    logic   [DEPTH-1:0] advance;

    // A stage moves unless it and every stage downstream of it are full while
    // the consumer stalls; sweeping from the output end avoids a feedback loop
    // through the advance vector.
    always_comb begin
        logic blocked;
        blocked = !out_ready_i;
        advance = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            blocked    = blocked && stage_q[s].valid;
            advance[s] = !blocked;
        end
    end

    assign in_ready_o = advance[0];

    always_comb begin
        stage_d[0].valid = in_valid_i && in_ready_o;
        stage_d[0].data  = in_data_i;
        for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    // NOTE: the data fields are reset too, so an empty output reads back as 0
    // rather than whatever was last in the chain before reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (advance[s]) begin
                    stage_q[s] <= stage_d[s];
                end
            end
        end
    end

    assign out_valid_o = stage_q[DEPTH-1].valid;
    assign out_data_o  = stage_q[DEPTH-1].data;

endmodule

// File: rtl/inner_inner_delay_unit.sv
// Two independent elastic delay lanes; lane i input feeds lane i output.
module inner_inner_delay_unit
    import delay_unit_pkg::*;
#(
    parameter int WIDTH = DELAY_WIDTH,
    parameter int DEPTH = DELAY_DEPTH
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] INPUT_0_data,
    input  logic             INPUT_0_valid,
    output logic             INPUT_0_ready,
    input  logic [WIDTH-1:0] INPUT_1_data,
    input  logic             INPUT_1_valid,
    output logic             INPUT_1_ready,
    output logic [WIDTH-1:0] OUTPUT_0_data,
    output logic             OUTPUT_0_valid,
    input  logic             OUTPUT_0_ready,
    output logic [WIDTH-1:0] OUTPUT_1_data,
    output logic             OUTPUT_1_valid,
    input  logic             OUTPUT_1_ready
);

    delay_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
        .clk         (CLK),
        .rst_n       (ASYNCRESETN),
        .in_data_i   (INPUT_0_data),
        .in_valid_i  (INPUT_0_valid),
        .in_ready_o  (INPUT_0_ready),
        .out_data_o  (OUTPUT_0_data),
        .out_valid_o (OUTPUT_0_valid),
        .out_ready_i (OUTPUT_0_ready)
    );

    delay_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
        .clk         (CLK),
        .rst_n       (ASYNCRESETN),
        .in_data_i   (INPUT_1_data),
        .in_valid_i  (INPUT_1_valid),
        .in_ready_o  (INPUT_1_ready),
        .out_data_o  (OUTPUT_1_data),
        .out_valid_o (OUTPUT_1_valid),
        .out_ready_i (OUTPUT_1_ready)
    );

endmodule

// File: tb/tb_inner_inner_delay_unit.sv
// Directed bench for the two-lane delay unit: inputs change just after the
// falling edge, outputs are sampled 1 time unit later (cycle k = value before the k-th rise).
module tb_inner_inner_delay_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] in0_data, in1_data, out0_data, out1_data;
    logic       in0_valid, in1_valid, in0_ready, in1_ready;
    logic       out0_valid, out1_valid, out0_ready, out1_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inner_inner_delay_unit dut (
        .CLK            (clk),
        .ASYNCRESETN    (rst_n),
        .INPUT_0_data   (in0_data),
        .INPUT_0_valid  (in0_valid),
        .INPUT_0_ready  (in0_ready),
        .INPUT_1_data   (in1_data),
        .INPUT_1_valid  (in1_valid),
        .INPUT_1_ready  (in1_ready),
        .OUTPUT_0_data  (out0_data),
        .OUTPUT_0_valid (out0_valid),
        .OUTPUT_0_ready (out0_ready),
        .OUTPUT_1_data  (out1_data),
        .OUTPUT_1_valid (out1_valid),
        .OUTPUT_1_ready (out1_ready)
    );

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in0_data = '0;
        in1_valid = 1'b0; in1_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out0_ready = 1'b1; out1_ready = 1'b1;
        rst_n = 1'b0;
        next_cycle();
        #1;
        total++;
        if ({out0_valid, out1_valid, in0_ready, in1_ready, out0_data, out1_data} !== {4'b0011, 10'h0}) begin
            bad++;
            $display("FAIL reset_hold: got ov0=%b ov1=%b ir0=%b ir1=%b d0=%h d1=%h, want 0 0 1 1 00 00",
                     out0_valid, out1_valid, in0_ready, in1_ready, out0_data, out1_data);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            total++;
            if ({out0_valid, out1_valid, out0_data, out1_data} !== 12'h0 || !in0_ready || !in1_ready) begin
                bad++;
                $display("FAIL idle_after_reset c%0d: got ov0=%b ov1=%b d0=%h d1=%h ir0=%b ir1=%b, want all 0, readies 1",
                         c, out0_valid, out1_valid, out0_data, out1_data, in0_ready, in1_ready);
            end
        end
    endtask

    task automatic test_latency();
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            in1_valid = (c == 0);
            in1_data  = (c == 0) ? 5'h15 : 5'h00;
            #1;
            total++;
            if (out1_valid !== (c == 3) || (c == 3 && out1_data !== 5'h15) || out0_valid !== 1'b0) begin
                bad++;
                $display("FAIL latency c%0d: got ov1=%b d1=%h ov0=%b, want ov1=%b d1=15 ov0=0",
                         c, out1_valid, out1_data, out0_valid, (c == 3));
            end
        end
        idle_inputs();
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 38; c++) begin
            next_cycle();
            in0_valid = (c < 32);
            in0_data  = 5'(c);
            #1;
            total++;
            if (out0_valid !== (c >= 3 && c <= 34) ||
                (c >= 3 && c <= 34 && out0_data !== 5'(c - 3)) || in0_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream c%0d: got ov0=%b d0=%h ir0=%b, want ov0=%b d0=%h ir0=1",
                         c, out0_valid, out0_data, in0_ready, (c >= 3 && c <= 34), 5'(c - 3));
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_pressure();
        logic [4:0] exp_out [4];
        logic       exp_rdy [5];
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_out = '{5'd1, 5'd2, 5'd3, 5'd4};
        out0_ready = 1'b0;
        // Offer 1..4 with the consumer stalled; only three fit.
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            in0_valid = 1'b1;
            in0_data  = (c < 3) ? 5'(c + 1) : 5'd4;
            #1;
            total++;
            if (in0_ready !== exp_rdy[c] || (c >= 3 && (out0_valid !== 1'b1 || out0_data !== 5'd1))) begin
                bad++;
                $display("FAIL backpressure_fill c%0d: got ir0=%b ov0=%b d0=%h, want ir0=%b (head 01 when full)",
                         c, in0_ready, out0_valid, out0_data, exp_rdy[c]);
            end
        end
        // Release: 4 is pushed at the same edge that pops 1.
        next_cycle();
        out0_ready = 1'b1;
        #1;
        total++;
        if (in0_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release_ready: got %b want 1", in0_ready);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                next_cycle();
                idle_inputs();
                #1;
            end
            total++;
            if (out0_valid !== (k < 4) || (k < 4 && out0_data !== exp_out[k])) begin
                bad++;
                $display("FAIL backpressure_drain k%0d: got ov0=%b d0=%h, want ov0=%b d0=%h",
                         k, out0_valid, out0_data, (k < 4), exp_out[k % 4]);
            end
        end
    endtask

    task automatic test_full_pop_push();
        logic [4:0] exp_seq [4];
        exp_seq = '{5'd7, 5'd8, 5'd9, 5'h1F};
        out0_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            in0_valid = 1'b1;
            in0_data  = 5'(7 + c);
        end
        next_cycle();
        in0_data = 5'h1F;
        #1;
        total++;
        if (in0_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_not_ready: got ir0=%b want 0", in0_ready);
        end
        next_cycle();
        out0_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                next_cycle();
                idle_inputs();
                #1;
            end
            total++;
            if (out0_valid !== (k < 4) || (k < 4 && out0_data !== exp_seq[k]) ||
                (k == 0 && in0_ready !== 1'b1)) begin
                bad++;
                $display("FAIL full_pop_push k%0d: got ov0=%b d0=%h ir0=%b, want ov0=%b d0=%h (ir0=1 at k0)",
                         k, out0_valid, out0_data, in0_ready, (k < 4), exp_seq[k % 4]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            in0_valid = 1'b1; in0_data = 5'(20 + c);
            in1_valid = 1'b1; in1_data = 5'(10 + c);
        end
        next_cycle();
        idle_inputs();
        #1;
        total++;
        if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
            bad++;
            $display("FAIL inflight_before_reset: got ov0=%b ov1=%b want 1 1", out0_valid, out1_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out0_valid, out1_valid, out0_data, out1_data} !== 12'h0 || !in0_ready || !in1_ready) begin
            bad++;
            $display("FAIL async_reset_immediate: got ov0=%b ov1=%b d0=%h d1=%h ir0=%b ir1=%b, want 0 0 00 00 1 1",
                     out0_valid, out1_valid, out0_data, out1_data, in0_ready, in1_ready);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            #1;
            total++;
            if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
                bad++;
                $display("FAIL stale_after_reset c%0d: got ov0=%b ov1=%b want 0 0", c, out0_valid, out1_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_streaming();
        test_back_pressure();
        test_full_pop_push();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
